// File: rtl/periph_bus_sequencer_pkg.sv
// Shared types and constants for the peripheral bus sequencer.
package periph_bus_pkg;

   localparam int unsigned NUM_PER = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // One-hot strobe pattern for a peripheral select value.
   function automatic logic [NUM_PER-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_PER-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/periph_bus_sequencer_if.sv
// CPU request/response channel plus the four-way peripheral strobe bus.
// The master modport is the sequencer's view; slave is the environment's view.
interface periph_bus_sequencer_if
   import periph_bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SEL_LSB = 8
);

   logic                          REQ_VALID;
   logic                          REQ_READY;
   logic [ADDR_W-1:0]             REQ_ADDR;
   logic                          REQ_WE;
   logic [DATA_W-1:0]             REQ_WDATA;
   logic                          RSP_VALID;
   logic [DATA_W-1:0]             RSP_RDATA;
   logic                          RSP_ERR;
   logic [NUM_PER-1:0]            PER_STB;
   logic                          PER_WE;
   logic [SEL_LSB-1:0]            PER_ADDR;
   logic [DATA_W-1:0]             PER_WDATA;
   logic [NUM_PER-1:0]            PER_ACK;
   logic [NUM_PER*DATA_W-1:0]     PER_RDATA;

   modport master (
      input  REQ_VALID, REQ_ADDR, REQ_WE, REQ_WDATA, PER_ACK, PER_RDATA,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
             PER_STB, PER_WE, PER_ADDR, PER_WDATA
   );

   modport slave (
      output REQ_VALID, REQ_ADDR, REQ_WE, REQ_WDATA, PER_ACK, PER_RDATA,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
             PER_STB, PER_WE, PER_ADDR, PER_WDATA
   );

endinterface

// File: rtl/periph_bus_sequencer_timeout_counter.sv
// Access wait counter: cleared at request accept, counts ACCESS cycles,
// and saturates with done=1 once it reaches TIMEOUT.
module periph_timeout_counter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   assign done = (count == CNT_W'(TIMEOUT));

   // Count up while enabled; holding at TIMEOUT keeps the counter from wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !done) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/periph_bus_sequencer.sv
// Single-outstanding MMIO sequencer: decodes one CPU request onto one of four
// peripherals, waits for its acknowledge (bounded by TIMEOUT) and returns a
// one-cycle response carrying read data or an error.
module periph_bus_sequencer
   import periph_bus_pkg::*;
#(
   parameter int unsigned       ADDR_W  = 32,
   parameter int unsigned       DATA_W  = 32,
   parameter int unsigned       SEL_LSB = 8,
   parameter logic [ADDR_W-1:0] BASE    = 32'h1100_0000,
   parameter int unsigned       TIMEOUT = 15
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   periph_bus_sequencer_if.master bus
);

   state_t               state_q, state_d;

   logic                 we_q;
   logic [SEL_LSB-1:0]   addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [SEL_W-1:0]     sel_q;

   logic [NUM_PER-1:0]   stb_q, stb_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

   logic                 cap_en;
   logic                 cnt_clr;
   logic                 cnt_en;
   logic                 cnt_done;

   logic [SEL_W-1:0]     req_sel;
   logic                 req_hit;
   logic                 ack_sel;
   logic [DATA_W-1:0]    rdata_sel;

   assign req_sel   = bus.REQ_ADDR[SEL_LSB +: SEL_W];
   assign req_hit   = (bus.REQ_ADDR[ADDR_W-1:SEL_LSB+SEL_W] == BASE[ADDR_W-1:SEL_LSB+SEL_W]);
   assign ack_sel   = bus.PER_ACK[sel_q];
   assign rdata_sel = bus.PER_RDATA[sel_q*DATA_W +: DATA_W];

   periph_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .done  (cnt_done)
   );

   // Next state plus the next values of the registered strobe and response.
   // The strobe is computed one cycle ahead so it drops on the same edge
   // that registers the response.
   always_comb begin
      state_d     = state_q;
      cap_en      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      stb_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.REQ_VALID) begin
               cap_en = 1'b1;
               if (req_hit) begin
                  state_d = ACCESS;
                  cnt_clr = 1'b1;
                  stb_d   = sel_onehot(req_sel);
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (ack_sel) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? '0 : rdata_sel;
            end else if (cnt_done) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_en = 1'b1;
               stb_d  = sel_onehot(sel_q);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, registered outputs and request capture.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         stb_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         sel_q       <= '0;
      end else begin
         state_q     <= state_d;
         stb_q       <= stb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         if (cap_en) begin
            we_q    <= bus.REQ_WE;
            addr_q  <= bus.REQ_ADDR[SEL_LSB-1:0];
            wdata_q <= bus.REQ_WDATA;
            sel_q   <= req_sel;
         end
      end
   end

   assign bus.REQ_READY = RST_N && (state_q == IDLE);
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_ERR   = rsp_err_q;
   assign bus.RSP_RDATA = rsp_rdata_q;
   assign bus.PER_STB   = stb_q;
   assign bus.PER_WE    = we_q;
   assign bus.PER_ADDR  = addr_q;
   assign bus.PER_WDATA = wdata_q;

endmodule

// File: tb/tb_periph_bus_sequencer.sv
// Self-checking bench for periph_bus_sequencer. Each transaction's expected
// cycle-by-cycle behaviour is derived from the address decode rule, the ack
// schedule the bench itself drives, and the timeout bound.
module tb_periph_bus_sequencer;

  localparam int          TO     = 15;
  localparam logic [31:0] BASE_A = 32'h1100_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  periph_bus_sequencer_if #(.ADDR_W(32), .DATA_W(32), .SEL_LSB(8)) bus ();

  periph_bus_sequencer #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SEL_LSB (8),
    .BASE    (BASE_A),
    .TIMEOUT (TO)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_WDATA = '0;
    bus.PER_ACK   = '0;
    bus.PER_RDATA = '0;
  endtask

  // Drive one request from an IDLE cycle (cycle 0 = accept edge) and check
  // every cycle up to and including the first IDLE cycle after the response.
  // ack_cycle: strobe cycle in which the selected ack is driven (0 = never).
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int ack_cycle, input bit noise, input logic [3:0] other_mask,
                        input logic [31:0] fixed_rd, input bit keep_valid);
    logic [31:0]  base_v;
    bit           hit;
    bit           err;
    int           sel;
    int           k;
    int           rspc;
    logic [31:0]  rd;
    logic [3:0]   ack_v;
    logic [127:0] rdv;
    logic [3:0]   exp_stb;
    logic         exp_rv;
    logic         exp_err;
    logic [31:0]  exp_rd;
    logic         exp_rdy;

    base_v = BASE_A;
    hit    = (addr[31:10] == base_v[31:10]);
    sel    = int'(addr[9:8]);
    if (!hit) begin
      k = 0; err = 1'b1; rspc = 1;
    end else if (ack_cycle >= 1 && ack_cycle <= TO + 1) begin
      k = ack_cycle; err = 1'b0; rspc = k + 1;
    end else begin
      k = TO + 1; err = 1'b1; rspc = TO + 2;
    end
    rd = '0;

    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = addr;
    bus.REQ_WE    = we;
    bus.REQ_WDATA = wdata;
    bus.PER_ACK   = '0;
    #1;
    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_accept addr=%h got=%b exp=1", addr, bus.REQ_READY);
    end

    for (int j = 1; j <= rspc + 1; j++) begin
      step();
      bus.REQ_VALID = keep_valid;
      ack_v = noise ? 4'($urandom) : other_mask;
      ack_v[sel] = (j == ack_cycle);
      for (int unsigned p = 0; p < 4; p++) rdv[p*32 +: 32] = $urandom;
      if (!noise) rdv[sel*32 +: 32] = fixed_rd;
      bus.PER_ACK   = ack_v;
      bus.PER_RDATA = rdv;
      if (hit && !err && !we && j == k) rd = rdv[sel*32 +: 32];
      #1;

      exp_stb = (hit && j <= k) ? (4'b0001 << sel) : 4'b0000;
      exp_rv  = (j == rspc);
      exp_err = exp_rv ? err : 1'b0;
      exp_rd  = exp_rv ? rd : 32'h0;
      exp_rdy = (j == rspc + 1);

      total++;
      if (bus.PER_STB !== exp_stb) begin
        bad++;
        $display("FAIL per_stb addr=%h cyc=%0d got=%b exp=%b", addr, j, bus.PER_STB, exp_stb);
      end
      total++;
      if (bus.RSP_VALID !== exp_rv) begin
        bad++;
        $display("FAIL rsp_valid addr=%h cyc=%0d got=%b exp=%b", addr, j, bus.RSP_VALID, exp_rv);
      end
      total++;
      if (bus.RSP_ERR !== exp_err) begin
        bad++;
        $display("FAIL rsp_err addr=%h cyc=%0d got=%b exp=%b", addr, j, bus.RSP_ERR, exp_err);
      end
      total++;
      if (bus.RSP_RDATA !== exp_rd) begin
        bad++;
        $display("FAIL rsp_rdata addr=%h cyc=%0d got=%h exp=%h", addr, j, bus.RSP_RDATA, exp_rd);
      end
      total++;
      if (bus.REQ_READY !== exp_rdy) begin
        bad++;
        $display("FAIL req_ready addr=%h cyc=%0d got=%b exp=%b", addr, j, bus.REQ_READY, exp_rdy);
      end
      if (exp_stb != 4'b0000) begin
        total++;
        if (bus.PER_WE !== we) begin
          bad++;
          $display("FAIL per_we addr=%h cyc=%0d got=%b exp=%b", addr, j, bus.PER_WE, we);
        end
        total++;
        if (bus.PER_ADDR !== addr[7:0]) begin
          bad++;
          $display("FAIL per_addr addr=%h cyc=%0d got=%h exp=%h", addr, j, bus.PER_ADDR, addr[7:0]);
        end
        total++;
        if (bus.PER_WDATA !== wdata) begin
          bad++;
          $display("FAIL per_wdata addr=%h cyc=%0d got=%h exp=%h", addr, j, bus.PER_WDATA, wdata);
        end
      end
    end
  endtask

  // Outputs held quiet while reset is asserted, ready after release.
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step(); step();
    total++;
    if (bus.REQ_READY !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=0", bus.REQ_READY);
    end
    total++;
    if (bus.RSP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp_valid got=%b exp=0", bus.RSP_VALID);
    end
    total++;
    if (bus.PER_STB !== 4'b0000) begin
      bad++;
      $display("FAIL reset_per_stb got=%b exp=0000", bus.PER_STB);
    end
    total++;
    if (bus.RSP_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp_err got=%b exp=0", bus.RSP_ERR);
    end
    total++;
    if (bus.RSP_RDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp_rdata got=%h exp=0", bus.RSP_RDATA);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.REQ_READY);
    end
  endtask

  task automatic test_read_hit();
    do_txn(32'h1100_0104, 1'b0, 32'h0, 1, 1'b0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_write_wait();
    do_txn(32'h1100_0300, 1'b1, 32'h0000_005A, 3, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_decode_miss();
    do_txn(32'h2200_0000, 1'b0, 32'h0, 1, 1'b0, 4'b1111, 32'h1111_1111, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(32'h1100_0000, 1'b0, 32'h0, 0,      1'b0, 4'b0000, 32'h0BAD_0BAD, 1'b0);
    do_txn(32'h1100_0000, 1'b0, 32'h0, TO + 1, 1'b0, 4'b0000, 32'h1234_5678, 1'b0);
    do_txn(32'h1100_0000, 1'b0, 32'h0, TO + 2, 1'b0, 4'b0000, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_wrong_ack();
    do_txn(32'h1100_0210, 1'b0, 32'h0, 0, 1'b0, 4'b0001, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(32'h1100_0108, 1'b1, 32'h0000_A5A5, 2, 1'b0, 4'b0000, 32'h0, 1'b1);
    do_txn(32'h1100_0108, 1'b1, 32'h0000_A5A5, 1, 1'b0, 4'b0000, 32'h0, 1'b0);
  endtask

  // Reset sampled in strobe cycle 2: strobe gone from cycle 3, no response.
  task automatic test_reset_mid();
    idle_inputs();
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 32'h1100_0200;
    step();
    bus.REQ_VALID = 1'b0;
    total++;
    if (bus.PER_STB !== 4'b0100) begin
      bad++;
      $display("FAIL mid_rst_stb_c1 got=%b exp=0100", bus.PER_STB);
    end
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.REQ_READY !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_ready_c2 got=%b exp=0", bus.REQ_READY);
    end
    for (int unsigned c = 3; c <= 4; c++) begin
      step();
      total++;
      if (bus.PER_STB !== 4'b0000) begin
        bad++;
        $display("FAIL mid_rst_stb cyc=%0d got=%b exp=0000", c, bus.PER_STB);
      end
      total++;
      if (bus.RSP_VALID !== 1'b0) begin
        bad++;
        $display("FAIL mid_rst_rsp cyc=%0d got=%b exp=0", c, bus.RSP_VALID);
      end
      total++;
      if (bus.REQ_READY !== 1'b0) begin
        bad++;
        $display("FAIL mid_rst_ready cyc=%0d got=%b exp=0", c, bus.REQ_READY);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_release_ready got=%b exp=1", bus.REQ_READY);
    end
    step();
    total++;
    if (bus.RSP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_no_rsp got=%b exp=0", bus.RSP_VALID);
    end
  endtask

  task automatic test_random();
    logic [31:0] base_v;
    logic [31:0] a;
    base_v = BASE_A;
    for (int unsigned n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = {base_v[31:10], 10'($urandom)};
      do_txn(a, 1'($urandom), $urandom, int'($urandom_range(0, TO + 3)), 1'b1, 4'b0000, 32'h0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_wait();
    test_decode_miss();
    test_timeout();
    test_wrong_ack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
